ebr_arbiter: RTL and testbench
==============================

EBR_ARBITER -- requirements
Module: ebr_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the word address width (256 x 16 EBR).
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the data and mask width.
REQ-003 The module SHALL have parameter CLEAR_ON_RESET, default 1; when 1, all words are zeroed after reset.
REQ-004 clk  in  1  single clock; the RAM read and write ports are both driven from it.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 a_req, b_req  in  1  access request from requester A or B; held until granted.
REQ-007 a_we, b_we  in  1  1 = write, 0 = read.
REQ-008 a_addr, b_addr  in  ADDR_W  word address.
REQ-009 a_wdata, b_wdata  in  DATA_W  write data.
REQ-010 a_wmask, b_wmask  in  DATA_W  per-bit write enable (1 = bit written).
REQ-011 a_gnt, b_gnt  out  1  combinational grant; a request completes in any cycle where req & gnt.
REQ-012 a_rvalid, b_rvalid  out  1  read data valid for that requester.
REQ-013 rdata  out  DATA_W  read data, shared by both requesters and qualified by a_rvalid/b_rvalid.
REQ-014 busy  out  1  high while the clear sweep runs.
REQ-015 ram_raddr, ram_waddr  out  ADDR_W  RAM read and write addresses.
REQ-016 ram_re, ram_we  out  1  RAM read and write enables.
REQ-017 ram_mask  out  DATA_W  RAM mask (1 = bit NOT written).
REQ-018 ram_wdata  out  DATA_W  RAM write data.
REQ-019 ram_rdata  in  DATA_W  RAM registered read data.

Function
REQ-020 The FSM SHALL have states CLEAR and RUN; it SHALL leave reset in CLEAR if CLEAR_ON_RESET = 1, else in RUN.
REQ-021 In CLEAR, a counter SHALL step 0 .. 2^ADDR_W-1, issuing one write per cycle with ram_wdata = 0, ram_mask = 0, ram_we = 1.
REQ-022 CLEAR SHALL go to RUN after the write to the last address; busy = 1 in CLEAR and 0 in RUN.
REQ-023 In CLEAR, a_gnt and b_gnt SHALL be 0.
REQ-024 In RUN, at most one grant SHALL be asserted per cycle, and only to a requester with req = 1.
REQ-025 With a single requester, it SHALL be granted in the same cycle.
REQ-026 With both requesting, a 1-bit round-robin pointer (reset value: A first) SHALL choose the winner.
REQ-027 After every grant, the pointer SHALL move to the non-granted requester, so neither requester waits more than one cycle.
REQ-028 A granted write SHALL drive ram_we = 1, ram_waddr = addr, ram_wdata = wdata, ram_mask = ~wmask in that cycle.
REQ-029 A granted read SHALL drive ram_re = 1, ram_raddr = addr in that cycle.
REQ-030 For a granted read, the requester's rvalid SHALL pulse exactly one cycle later, with rdata = ram_rdata.
REQ-031 Back-to-back grants SHALL give full throughput: 1 access per cycle, with no idle cycle between a write and a read.
REQ-032 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-033 A write with wmask = 0 SHALL leave memory unchanged but still complete the handshake.
REQ-034 ram_we, ram_re SHALL be 0 in cycles with no grant and not in CLEAR; address and data outputs are don't-care then.
REQ-035 Address wrap SHALL not occur: the clear counter stops at the last address; request addresses are used as given, modulo 2^ADDR_W.

Reset
REQ-036 On rst, the following SHALL clear immediately, without waiting for clk: gnt, rvalid, ram_we, ram_re, the clear counter and the pointer.
REQ-037 On rst, rdata SHALL be 0 and busy SHALL be CLEAR_ON_RESET.
REQ-038 rst asserted mid-sweep or mid-read SHALL discard the pending rvalid and restart the sweep from address 0 after release.

Verification
REQ-039 Reset release, CLEAR_ON_RESET = 1 -> busy high 256 cycles with waddr 0..255, then busy = 0; a read of 0x37 -> rdata 0x0000.
REQ-040 A writes 0x12AB to 0x10 with wmask 0xFFFF; next cycle A reads 0x10 -> a_rvalid one cycle after the read grant, rdata = 0x12AB, b_rvalid = 0.
REQ-041 A and B request every cycle for 8 cycles -> grants alternate A, B, A, B ...; each requester gets 4 grants.
REQ-042 Word 0x20 = 0xFFFF; B writes 0x0000 with wmask 0x00FF -> ram_mask = 0xFF00; a read of 0x20 returns 0xFF00.
REQ-043 Assert rst at sweep address 100, release -> busy restarts, waddr restarts from 0, no rvalid appears.
REQ-044 CLEAR_ON_RESET = 0 -> busy = 0 and A is granted in the first cycle after reset.

Source files
------------

// File: rtl/ebr_arbiter_if.sv
// Requester, status and RAM-side signals of the two-requester EBR arbiter.
// The slave modport is the arbiter; the master modport is whatever surrounds it.
interface ebr_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_wmask;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_wmask;
    logic              a_gnt;
    logic              b_gnt;
    logic              a_rvalid;
    logic              b_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              state_dbg;
    logic [ADDR_W-1:0] ram_raddr;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_mask;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Handshake: a request is held with stable fields until req & gnt in the
    // same cycle; gnt is combinational. A read's rvalid pulses one cycle later.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_wmask,
        input  b_req, b_we, b_addr, b_wdata, b_wmask,
        input  ram_rdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy, state_dbg,
        output ram_raddr, ram_waddr, ram_re, ram_we, ram_mask, ram_wdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_wmask,
        output b_req, b_we, b_addr, b_wdata, b_wmask,
        output ram_rdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy, state_dbg,
        input  ram_raddr, ram_waddr, ram_re, ram_we, ram_mask, ram_wdata
    );
endinterface

// File: rtl/ebr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-clock EBR with
// registered read data, plus an optional zeroing sweep after reset.
module ebr_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    ebr_arbiter_if.slave  bus
);
    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic              ptr;        // 0: A wins a tie, 1: B wins a tie
    logic              ptr_nxt;
    logic              a_rv;
    logic              b_rv;

    logic              a_gnt;
    logic              b_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_wmask;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            ptr     <= 1'b0;
            a_rv    <= 1'b0;
            b_rv    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ptr     <= ptr_nxt;
            a_rv    <= a_gnt & ~bus.a_we;
            b_rv    <= b_gnt & ~bus.b_we;
        end
    end

    // Strobes are gated by rst so they drop the instant reset is asserted.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ptr_nxt     = ptr;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_wmask   = '0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = '0;
        ram_raddr   = '0;
        ram_wdata   = '0;
        ram_mask    = '1;

        case (state)
            S_CLEAR: begin
                if (!rst) begin
                    ram_we    = 1'b1;
                    ram_waddr = clr_cnt;
                    ram_wdata = '0;
                    ram_mask  = '0;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt = S_RUN;
                    end else begin
                        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (!rst) begin
                    if (bus.a_req && (!bus.b_req || !ptr)) begin
                        a_gnt = 1'b1;
                    end else if (bus.b_req) begin
                        b_gnt = 1'b1;
                    end

                    if (a_gnt) begin
                        ptr_nxt   = 1'b1;
                        sel_we    = bus.a_we;
                        sel_addr  = bus.a_addr;
                        sel_wdata = bus.a_wdata;
                        sel_wmask = bus.a_wmask;
                    end else if (b_gnt) begin
                        ptr_nxt   = 1'b0;
                        sel_we    = bus.b_we;
                        sel_addr  = bus.b_addr;
                        sel_wdata = bus.b_wdata;
                        sel_wmask = bus.b_wmask;
                    end

                    if (a_gnt || b_gnt) begin
                        if (sel_we) begin
                            ram_we    = 1'b1;
                            ram_waddr = sel_addr;
                            ram_wdata = sel_wdata;
                            ram_mask  = ~sel_wmask;
                        end else begin
                            ram_re    = 1'b1;
                            ram_raddr = sel_addr;
                        end
                    end
                end
            end

            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    assign bus.a_gnt     = a_gnt;
    assign bus.b_gnt     = b_gnt;
    assign bus.a_rvalid  = a_rv;
    assign bus.b_rvalid  = b_rv;
    // rdata is forced to zero outside a valid pulse so reset reads back 0.
    assign bus.rdata     = (a_rv || b_rv) ? bus.ram_rdata : '0;
    assign bus.busy      = (state == S_CLEAR);
    assign bus.state_dbg = (state == S_CLEAR);
    assign bus.ram_we    = ram_we;
    assign bus.ram_re    = ram_re;
    assign bus.ram_waddr = ram_waddr;
    assign bus.ram_raddr = ram_raddr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_mask  = ram_mask;
endmodule

// File: tb/tb_ebr_arbiter.sv
// Directed bench for ebr_arbiter: clear sweep, arbitration, masked writes,
// read latency and reset behaviour, against a registered-read RAM model.
module tb_ebr_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;
    int   a_cnt = 0;
    int   b_cnt = 0;
    logic prev_a;

    always #5 clk = ~clk;

    ebr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    ebr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    ebr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ebr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    // RAM model: mask bit 1 keeps the old bit; read data registered.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_waddr] <= (mem[bus.ram_waddr] & bus.ram_mask) |
                                  (bus.ram_wdata & ~bus.ram_mask);
        if (bus.ram_re)
            bus.ram_rdata <= mem[bus.ram_raddr];
    end
    assign bus0.ram_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr;
        bus.a_wdata = wdata; bus.a_wmask = wmask;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr;
        bus.b_wdata = wdata; bus.b_wmask = wmask;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
        bus0.a_req = 1'b1; bus0.a_we = 1'b0; bus0.a_addr = 8'h05;
        bus0.a_wdata = '0; bus0.a_wmask = '0;
        bus0.b_req = 1'b1; bus0.b_we = 1'b0; bus0.b_addr = 8'h06;
        bus0.b_wdata = '0; bus0.b_wmask = '0;

        // ---- reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",     32'(bus.busy), 1);
        chk("rst_a_gnt",    32'(bus.a_gnt), 0);
        chk("rst_rdata",    32'(bus.rdata), 0);
        chk("rst_ram_we",   32'(bus.ram_we), 0);
        chk("rst_ram_re",   32'(bus.ram_re), 0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("rst0_busy",    32'(bus0.busy), 0);
        chk("rst0_a_gnt",   32'(bus0.a_gnt), 0);

        // ---- clear sweep; A's read of 0x37 is held throughout
        set_a(1, 0, 8'h37, '0, '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("swp_busy",  32'(bus.busy), 1);
            chk("swp_we",    32'(bus.ram_we), 1);
            chk("swp_waddr", 32'(bus.ram_waddr), 32'(i));
            chk("swp_mask",  32'(bus.ram_mask), 0);
            chk("swp_wdata", 32'(bus.ram_wdata), 0);
            chk("swp_a_gnt", 32'(bus.a_gnt), 0);
            if (i == 0) begin
                chk("nc_a_gnt_first", 32'(bus0.a_gnt), 1);
                chk("nc_b_gnt_first", 32'(bus0.b_gnt), 0);
                chk("nc_busy",        32'(bus0.busy), 0);
                chk("nc_ram_re",      32'(bus0.ram_re), 1);
                chk("nc_raddr",       32'(bus0.ram_raddr), 32'h05);
            end
            if (i == 1) begin
                chk("nc_b_gnt_second", 32'(bus0.b_gnt), 1);
                chk("nc_a_gnt_second", 32'(bus0.a_gnt), 0);
                chk("nc_a_rvalid",     32'(bus0.a_rvalid), 1);
                bus0.a_req = 1'b0;
                bus0.b_req = 1'b0;
            end
        end

        // ---- first RUN cycle: read 0x37 granted
        @(negedge clk);
        chk("run_busy",   32'(bus.busy), 0);
        chk("rd37_gnt",   32'(bus.a_gnt), 1);
        chk("rd37_bgnt",  32'(bus.b_gnt), 0);
        chk("rd37_re",    32'(bus.ram_re), 1);
        chk("rd37_raddr", 32'(bus.ram_raddr), 32'h37);
        chk("rd37_we",    32'(bus.ram_we), 0);

        // ---- A writes 0x12AB to 0x10 directly after the read
        tick();
        set_a(1, 1, 8'h10, 16'h12AB, 16'hFFFF);
        @(negedge clk);
        chk("rd37_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd37_rdata",  32'(bus.rdata), 0);
        chk("wr10_gnt",    32'(bus.a_gnt), 1);
        chk("wr10_we",     32'(bus.ram_we), 1);
        chk("wr10_re",     32'(bus.ram_re), 0);
        chk("wr10_waddr",  32'(bus.ram_waddr), 32'h10);
        chk("wr10_wdata",  32'(bus.ram_wdata), 32'h12AB);
        chk("wr10_mask",   32'(bus.ram_mask), 0);

        tick();
        set_a(1, 0, 8'h10, '0, '0);
        @(negedge clk);
        chk("rd10_gnt",    32'(bus.a_gnt), 1);
        chk("rd10_re",     32'(bus.ram_re), 1);
        chk("rd10_raddr",  32'(bus.ram_raddr), 32'h10);
        chk("rd10_we",     32'(bus.ram_we), 0);
        chk("rd10_early",  32'(bus.a_rvalid), 0);

        tick();
        set_a(0, 0, '0, '0, '0);
        @(negedge clk);
        chk("rd10_rvalid",  32'(bus.a_rvalid), 1);
        chk("rd10_rdata",   32'(bus.rdata), 32'h12AB);
        chk("rd10_brvalid", 32'(bus.b_rvalid), 0);
        chk("idle_we",      32'(bus.ram_we), 0);
        chk("idle_re",      32'(bus.ram_re), 0);

        // ---- masked writes to 0x20
        tick();
        set_a(1, 1, 8'h20, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        chk("wr20_gnt", 32'(bus.a_gnt), 1);

        tick();
        set_a(0, 0, '0, '0, '0);
        set_b(1, 1, 8'h20, 16'h0000, 16'h00FF);
        @(negedge clk);
        chk("bwr_gnt",  32'(bus.b_gnt), 1);
        chk("bwr_agnt", 32'(bus.a_gnt), 0);
        chk("bwr_mask", 32'(bus.ram_mask), 32'hFF00);
        chk("bwr_wdat", 32'(bus.ram_wdata), 0);

        tick();
        set_b(0, 0, '0, '0, '0);
        set_a(1, 0, 8'h20, '0, '0);
        @(negedge clk);
        chk("rd20_gnt", 32'(bus.a_gnt), 1);

        tick();
        set_a(0, 0, '0, '0, '0);
        set_b(1, 1, 8'h20, 16'h1234, 16'h0000);
        @(negedge clk);
        chk("rd20_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd20_rdata",  32'(bus.rdata), 32'hFF00);
        chk("m0_gnt",      32'(bus.b_gnt), 1);
        chk("m0_we",       32'(bus.ram_we), 1);
        chk("m0_mask",     32'(bus.ram_mask), 32'hFFFF);

        tick();
        set_b(0, 0, '0, '0, '0);
        set_a(1, 0, 8'h20, '0, '0);
        @(negedge clk);
        chk("rd20b_gnt", 32'(bus.a_gnt), 1);

        tick();
        set_a(0, 0, '0, '0, '0);
        set_b(1, 0, 8'h10, '0, '0);
        @(negedge clk);
        chk("m0_unchanged", 32'(bus.rdata), 32'hFF00);
        chk("brd_gnt",      32'(bus.b_gnt), 1);

        tick();
        set_b(0, 0, '0, '0, '0);
        @(negedge clk);
        chk("brd_rvalid",  32'(bus.b_rvalid), 1);
        chk("brd_arvalid", 32'(bus.a_rvalid), 0);
        chk("brd_rdata",   32'(bus.rdata), 32'h12AB);

        // ---- both request for 8 cycles; pointer currently favours A
        tick();
        set_a(1, 0, 8'h10, '0, '0);
        set_b(1, 0, 8'h20, '0, '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_a_gnt", 32'(bus.a_gnt), 32'(k % 2 == 0));
            chk("rr_b_gnt", 32'(bus.b_gnt), 32'(k % 2 != 0));
            if (bus.a_gnt) a_cnt++;
            if (bus.b_gnt) b_cnt++;
            if (k > 0) begin
                chk("rr_a_rvalid", 32'(bus.a_rvalid), 32'(prev_a));
                chk("rr_b_rvalid", 32'(bus.b_rvalid), 32'(!prev_a));
                chk("rr_rdata",    32'(bus.rdata), prev_a ? 32'h12AB : 32'hFF00);
            end
            prev_a = (k % 2 == 0);
            tick();
        end
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
        @(negedge clk);
        chk("rr_last_brvalid", 32'(bus.b_rvalid), 1);
        chk("rr_last_rdata",   32'(bus.rdata), 32'hFF00);
        chk("rr_a_count",      32'(a_cnt), 4);
        chk("rr_b_count",      32'(b_cnt), 4);

        // ---- reset during a pending read
        tick();
        set_a(1, 0, 8'h10, '0, '0);
        @(negedge clk);
        chk("pend_gnt", 32'(bus.a_gnt), 1);
        tick();
        set_a(0, 0, '0, '0, '0);
        rst = 1'b1;
        #1;
        chk("pend_rvalid_drop", 32'(bus.a_rvalid), 0);
        chk("pend_rdata",       32'(bus.rdata), 0);
        chk("pend_busy",        32'(bus.busy), 1);
        chk("pend_we",          32'(bus.ram_we), 0);
        tick();
        rst = 1'b0;

        // ---- reset at sweep address 100, then a full restarted sweep
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            chk("s1_waddr",  32'(bus.ram_waddr), 32'(i));
            chk("s1_rvalid", 32'(bus.a_rvalid), 0);
        end
        rst = 1'b1;
        #1;
        chk("s1_rst_busy", 32'(bus.busy), 1);
        chk("s1_rst_we",   32'(bus.ram_we), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("s2_busy",    32'(bus.busy), 1);
            chk("s2_waddr",   32'(bus.ram_waddr), 32'(i));
            chk("s2_arvalid", 32'(bus.a_rvalid), 0);
            chk("s2_brvalid", 32'(bus.b_rvalid), 0);
        end
        @(negedge clk);
        chk("s2_done_busy", 32'(bus.busy), 0);
        chk("s2_done_we",   32'(bus.ram_we), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
